multi_4bits_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 4x4 multiplier (tt_um_carlosgs99_multi_4bits datapath) between two requesters.
- Accepts operand pairs over valid/ready handshakes.
- Drives the shared multiplier from registered operands and waits MUL_LAT cycles.
- Captures the product and returns it, tagged with the requester ID, over a valid/ready result port.
- Sits between the top-level IO wrapper and the multiplier instance.

---
 rtl/multi_4bits_arbiter_if.sv | 28 ++
 rtl/multi_4bits_arbiter.sv | 149 ++++++++++++++
 tb/tb_multi_4bits_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_4bits_arbiter_if.sv
// Handshake bundle between two operand requesters, the result consumer and the arbiter.
// slave is the arbiter side; master is the requester/consumer side.
interface multi_4bits_arbiter_if #(
    parameter int WIDTH = 4
);
    logic               req0_valid;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req0_ready;
    logic               req1_valid;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic               req1_ready;
    logic               res_valid;
    logic               res_id;
    logic [2*WIDTH-1:0] res_p;
    logic               res_ready;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_id, res_p
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_id, res_p
    );
endinterface

// File: rtl/multi_4bits_arbiter.sv
// Round-robin sequencer sharing one combinational multiplier between two requesters.
// Optional per-requester delivered-result counters when ARB_STATS_EN is defined.
module multi_4bits_arbiter #(
    parameter int WIDTH   = 4,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    multi_4bits_arbiter_if.slave bus,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p
`ifdef ARB_STATS_EN
    ,
    output logic [7:0]           cnt0,
    output logic [7:0]           cnt1
`endif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(MUL_LAT - 1);

    state_t             state_reg, state_next;
    logic               last_grant_reg, last_grant_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [WIDTH-1:0]   mul_a_reg, mul_a_next;
    logic [WIDTH-1:0]   mul_b_reg, mul_b_next;
    logic               res_valid_reg, res_valid_next;
    logic               res_id_reg, res_id_next;
    logic [2*WIDTH-1:0] res_p_reg, res_p_next;

    logic grant;
    logic any_valid;
    logic ready0;
    logic ready1;
    logic accept;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_reg;
        end else begin
            grant = ~bus.req0_valid;
        end
        ready0 = ena && (state_reg == IDLE) && any_valid && !grant;
        ready1 = ena && (state_reg == IDLE) && any_valid && grant;
        accept = (ready0 && bus.req0_valid) || (ready1 && bus.req1_valid);
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        mul_a_next      = mul_a_reg;
        mul_b_next      = mul_b_reg;
        res_valid_next  = res_valid_reg;
        res_id_next     = res_id_reg;
        res_p_next      = res_p_reg;
        if (ena) begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        mul_a_next      = grant ? bus.req1_a : bus.req0_a;
                        mul_b_next      = grant ? bus.req1_b : bus.req0_b;
                        res_id_next     = grant;
                        last_grant_next = grant;
                        cnt_next        = LAT_INIT;
                        state_next      = MUL;
                    end
                end
                MUL: begin
                    if (cnt_reg == 4'd0) begin
                        res_p_next     = mul_p;
                        res_valid_next = 1'b1;
                        state_next     = DONE;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_next = 1'b0;
                        state_next     = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            cnt_reg        <= 4'd0;
            mul_a_reg      <= '0;
            mul_b_reg      <= '0;
            res_valid_reg  <= 1'b0;
            res_id_reg     <= 1'b0;
            res_p_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            mul_a_reg      <= mul_a_next;
            mul_b_reg      <= mul_b_next;
            res_valid_reg  <= res_valid_next;
            res_id_reg     <= res_id_next;
            res_p_reg      <= res_p_next;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.res_valid  = res_valid_reg;
    assign bus.res_id     = res_id_reg;
    assign bus.res_p      = res_p_reg;
    assign mul_a          = mul_a_reg;
    assign mul_b          = mul_b_reg;

`ifdef ARB_STATS_EN
    logic [7:0] stat_reg [2];
    logic       deliver;

    assign deliver = ena && res_valid_reg && bus.res_ready;

    // One saturating delivery counter per requester.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            always_ff @(posedge clk) begin
                if (rst) begin
                    stat_reg[gi] <= 8'd0;
                end else if (deliver && (res_id_reg == 1'(gi)) && (stat_reg[gi] != 8'hFF)) begin
                    stat_reg[gi] <= stat_reg[gi] + 8'd1;
                end
            end
        end
    endgenerate

    assign cnt0 = stat_reg[0];
    assign cnt1 = stat_reg[1];
`endif
endmodule

// File: tb/tb_multi_4bits_arbiter.sv
// Scoreboard bench: products are queued at each accept and compared at each result handshake.
module tb_multi_4bits_arbiter;
    localparam int WIDTH   = 4;
    localparam int MUL_LAT = 3;

    logic clk;
    logic rst;
    logic ena;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] mul_p;
`ifdef ARB_STATS_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
`endif

    multi_4bits_arbiter_if #(.WIDTH(WIDTH)) bus ();

    multi_4bits_arbiter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .bus   (bus.slave),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_p (mul_p)
`ifdef ARB_STATS_EN
        ,
        .cnt0  (cnt0),
        .cnt1  (cnt1)
`endif
    );

    // Stand-in for the shared combinational multiplier.
    assign mul_p = 8'(mul_a) * 8'(mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int deliv0   = 0;
    logic [2*WIDTH:0] sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor sits on the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else if (ena) begin
            if (bus.req0_ready || bus.req1_ready)
                check_eq("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.req0_valid && bus.req0_ready) begin
                sb.push_back({1'b0, 8'(bus.req0_a) * 8'(bus.req0_b)});
                $display("accept req0 %0d x %0d", bus.req0_a, bus.req0_b);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                sb.push_back({1'b1, 8'(bus.req1_a) * 8'(bus.req1_b)});
                $display("accept req1 %0d x %0d", bus.req1_a, bus.req1_b);
            end
            if (bus.res_valid && bus.res_ready) begin
                check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    logic [2*WIDTH:0] e;
                    e = sb.pop_front();
                    $display("result id=%0d p=%0d (expected id=%0d p=%0d)",
                             bus.res_id, bus.res_p, e[2*WIDTH], e[2*WIDTH-1:0]);
                    check_eq("res_p", 32'(bus.res_p), 32'(e[2*WIDTH-1:0]));
                    check_eq("res_id", 32'(bus.res_id), 32'(e[2*WIDTH]));
                end
                if (!bus.res_id) deliv0++;
            end
        end
    end

    task automatic wait_grant(output int who);
        int seen = 0;
        who = -1;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin who = 0; seen = 1; end
            else if (bus.req1_ready) begin who = 1; seen = 1; end
        end
        check_eq("grant_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_result(output int lat);
        int seen = 0;
        lat = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge clk);
            lat++;
            if (bus.res_valid) seen = 1;
        end
        check_eq("result_seen", 32'(seen), 32'd1);
    endtask

    // Called just after a rising edge: withdraw requests and let pending results drain.
    task automatic drain();
        int done = 0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready  = 1'b1;
        for (int i = 0; i < 80 && done == 0; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.res_valid) done = 1;
        end
        check_eq("drained", 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int id, input int a, input int b);
        if (id == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = 4'(a); bus.req0_b = 4'(b);
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = 4'(b == -1 ? 0 : a); bus.req1_b = 4'(b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int who;
        int lat;
        rst = 1'b1; ena = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.res_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mul_a", 32'(mul_a), 32'd0);
        check_eq("rst_mul_b", 32'(mul_b), 32'd0);
        check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_eq("rst_res_id", 32'(bus.res_id), 32'd0);
        check_eq("rst_res_p", 32'(bus.res_p), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request and accept-to-result latency
        bus.res_ready = 1'b1;
        set_req(0, 3, 5);
        wait_grant(who);
        check_eq("t1_grant", 32'(who), 32'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        wait_result(lat);
        check_eq("t1_latency", 32'(lat), 32'(MUL_LAT + 1));
        check_eq("t1_res_p", 32'(bus.res_p), 32'd15);
        check_eq("t1_res_id", 32'(bus.res_id), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t1_release", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;

        // Both requesters continuously valid after reset: strict alternation from req0
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, 15, 15);
        set_req(1, 2, 7);
        for (int i = 0; i < 6; i++) begin
            wait_grant(who);
            check_eq("t2_rr", 32'(who), 32'(i % 2));
            @(posedge clk); #1;
        end
        drain();

        // Result backpressure holds the result and blocks new accepts
        bus.res_ready = 1'b0;
        set_req(1, 4, 6);
        wait_grant(who);
        check_eq("t3_grant", 32'(who), 32'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        set_req(0, 2, 3);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_hold_valid", 32'(bus.res_valid), 32'd1);
            check_eq("t3_hold_p", 32'(bus.res_p), 32'd24);
            check_eq("t3_hold_id", 32'(bus.res_id), 32'd1);
            check_eq("t3_no_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        wait_grant(who);
        check_eq("t3_next_grant", 32'(who), 32'd0);
        @(posedge clk); #1;
        drain();

        // ena low in MUL freezes the countdown for 4 cycles
        bus.res_ready = 1'b0;
        set_req(0, 7, 3);
        wait_grant(who);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        ena = 1'b0;
        set_req(1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t4_frozen_mul_a", 32'(mul_a), 32'd7);
            check_eq("t4_frozen_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        end
        @(posedge clk); #1;
        ena = 1'b1;
        bus.req1_valid = 1'b0;
        wait_result(lat);
        check_eq("t4_latency", 32'(lat + 4), 32'(MUL_LAT + 1 + 4));
        check_eq("t4_res_p", 32'(bus.res_p), 32'd21);
        @(posedge clk); #1;
        ena = 1'b0;
        bus.res_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("t4_ena_hold_valid", 32'(bus.res_valid), 32'd1);
        end
        @(posedge clk); #1;
        ena = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t4_release", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;

        // Reset in MUL discards the in-flight 9x9
        set_req(1, 9, 9);
        wait_grant(who);
        check_eq("t5_grant", 32'(who), 32'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_mul_a", 32'(mul_a), 32'd0);
        check_eq("t5_mul_b", 32'(mul_b), 32'd0);
        check_eq("t5_res_p", 32'(bus.res_p), 32'd0);
        check_eq("t5_res_id", 32'(bus.res_id), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check_eq("t5_no_result", 32'(bus.res_valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        set_req(0, 1, 2);
        set_req(1, 3, 4);
        wait_grant(who);
        check_eq("t5_tie_grant", 32'(who), 32'd0);
        @(posedge clk); #1;
        drain();

`ifdef ARB_STATS_EN
        // Saturating delivery counters
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        deliv0 = 0;
        @(negedge clk);
        check_eq("st_rst_cnt0", 32'(cnt0), 32'd0);
        @(posedge clk); #1;
        set_req(0, 1, 1);
        for (int i = 0; i < 4000 && deliv0 < 300; i++) @(posedge clk);
        #1;
        drain();
        check_eq("st_delivered", 32'(deliv0 >= 300), 32'd1);
        check_eq("st_cnt0", 32'(cnt0), 32'd255);
        check_eq("st_cnt1", 32'(cnt1), 32'd0);
`endif

        check_eq("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
